// File: rtl/bsg_startup_seq_pkg.sv
// Shared types for the startup sequencer: FSM state encoding and width helper.
package bsg_startup_seq_pkg;

  localparam logic [1:0] WaitReadyEnc = 2'd0;
  localparam logic [1:0] StageEnc     = 2'd1;
  localparam logic [1:0] DoneEnc      = 2'd2;
  localparam logic [1:0] ErrorEnc     = 2'd3;

  typedef enum logic [1:0] {
    StWaitReady = WaitReadyEnc,
    StStage     = StageEnc,
    StDone      = DoneEnc,
    StError     = ErrorEnc
  } state_e;

  // Stage index width; a single-stage build still needs one bit.
  function automatic int unsigned stage_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_startup_seq_if.sv
// Handshake bundle between the startup sequencer and its upstream/downstream logic.
interface bsg_startup_seq_if
  import bsg_startup_seq_pkg::*;
#(
  parameter int unsigned num_stages_p = 4
) ();

  localparam int unsigned StageW = stage_idx_w(num_stages_p);

  logic                    ready_i;
  logic [num_stages_p-1:0] stage_ack_i;
  logic [num_stages_p-1:0] stage_en_o;
  logic                    done_o;
  logic                    error_o;
  logic [StageW-1:0]       error_stage_o;

  modport master (
    output ready_i, stage_ack_i,
    input  stage_en_o, done_o, error_o, error_stage_o
  );

  modport slave (
    input  ready_i, stage_ack_i,
    output stage_en_o, done_o, error_o, error_stage_o
  );

endinterface

// File: rtl/bsg_startup_sequencer_sync.sv
// Two-flop synchronizer for asynchronous stage acknowledges.
module bsg_sync_sync #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] meta_q;
  logic [width_p-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= data_i;
      sync_q <= meta_q;
    end
  end

  assign data_o = sync_q;

endmodule

// File: rtl/bsg_startup_sequencer.sv
// Ordered bring-up of downstream stages with per-stage ack timeout.
// Define BSG_STARTUP_SEQ_ACK_SYNC_EN to pass acks through a two-flop synchronizer.
module bsg_startup_sequencer
  import bsg_startup_seq_pkg::*;
#(
  parameter int unsigned num_stages_p = 4,
  parameter int unsigned lg_timeout_p = 6
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  bsg_startup_seq_if.slave   bus
);

  localparam int unsigned StageW = stage_idx_w(num_stages_p);
  localparam logic [StageW-1:0]       LastK  = StageW'(num_stages_p - 1);
  localparam logic [num_stages_p-1:0] EnOne  = num_stages_p'(1);

  logic [num_stages_p-1:0] ack;

`ifdef BSG_STARTUP_SEQ_ACK_SYNC_EN
  bsg_sync_sync #(
    .width_p(num_stages_p)
  ) u_ack_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (bus.stage_ack_i),
    .data_o   (ack)
  );
`else
  assign ack = bus.stage_ack_i;
`endif

  state_e                  state_q;
  logic [StageW-1:0]       k_q;
  logic [lg_timeout_p-1:0] t_q;
  logic [num_stages_p-1:0] en_q;
  logic                    done_q;
  logic                    err_q;
  logic [StageW-1:0]       err_stage_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StWaitReady;
      k_q         <= '0;
      t_q         <= '0;
      en_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else if (!bus.ready_i) begin
      // Losing ready abandons the bring-up from any state.
      state_q     <= StWaitReady;
      k_q         <= '0;
      t_q         <= '0;
      en_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      unique case (state_q)
        StWaitReady: begin
          state_q <= StStage;
          k_q     <= '0;
          t_q     <= '0;
          en_q    <= EnOne;
        end
        StStage: begin
          if (ack[k_q]) begin
            if (k_q == LastK) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              k_q  <= k_q + 1'b1;
              t_q  <= '0;
              en_q <= (en_q << 1) | EnOne;
            end
          end else if (t_q == '1) begin
            state_q     <= StError;
            err_q       <= 1'b1;
            err_stage_q <= k_q;
            en_q        <= '0;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        StDone:  ;
        StError: ;
        default: state_q <= StWaitReady;
      endcase
    end
  end

  assign bus.stage_en_o    = en_q;
  assign bus.done_o        = done_q;
  assign bus.error_o       = err_q;
  assign bus.error_stage_o = err_stage_q;

endmodule

// File: doc/bsg_startup_sequencer.md
# bsg_startup_sequencer

Consumes the `ready` output of the post-reset wait counter and brings up downstream stages in order. It asserts one cumulative enable per stage and waits for that stage's acknowledge before moving on. A per-stage timeout flags a stage that never acknowledges. The block sits directly after the wait-after-reset stage and before the clock-gate and power-enable controls of the downstream stages.

## Interface
Parameters:
- `num_stages_p`, default 4: number of sequenced stages, 1..16.
- `lg_timeout_p`, default 6: the ack must arrive within 2^`lg_timeout_p` cycles of the enable.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `ready_i`  in  1  from the wait-after-reset stage; level, synchronous to `clk_i`.
- `stage_ack_i`  in  `num_stages_p`  per-stage acknowledge, level.
- `stage_en_o`  out  `num_stages_p`  per-stage enable, registered, cumulative.
- `done_o`  out  1  all stages acknowledged; registered.
- `error_o`  out  1  timeout occurred; sticky, registered.
- `error_stage_o`  out  max(1,clog2(`num_stages_p`))  index of the stage that timed out.

## Operation
- States: `WAIT_READY`, `STAGE`, `DONE`, `ERROR`.
- Registers: stage index `k` and timer `t`, which is `lg_timeout_p` bits wide.
- `WAIT_READY`:
  - All outputs are 0.
  - On `ready_i`=1, go to `STAGE` with k=0 and t=0, and set `stage_en_o[0]`.
- `STAGE` (k):
  - If ack[k] is sampled 1:
    - When k=`num_stages_p`-1, go to `DONE`.
    - Otherwise set k=k+1, t=0, and set `stage_en_o[k+1]`.
  - If no ack and t=2^`lg_timeout_p`-1:
    - Go to `ERROR`.
    - Latch `error_stage_o`=k.
    - Clear all `stage_en_o` bits.
  - Otherwise t=t+1. The timer saturates and never wraps.
- Ack and timeout in the same cycle: ack wins.
- Acks on stages other than k are ignored. This covers early acks from later stages and deasserted acks from already-passed stages.
- `DONE`: `done_o`=1, all enables held at 1. Acks are no longer monitored.
- `ERROR`: `error_o`=1 and all enables are 0. The state holds until reset or until `ready_i`=0.
- `ready_i`=0 in any state:
  - Next cycle the state is `WAIT_READY`.
  - All enables, `done_o`, `error_o`, `error_stage_o`, k and t are cleared.
  - This takes priority over every other transition.

## Timing
- Reset values: `stage_en_o`=0, `done_o`=0, `error_o`=0, `error_stage_o`=0, state=`WAIT_READY`, k=0, t=0.
- `ready_i` rises in cycle c: `stage_en_o[0]`=1 in cycle c+1.
- Ack[k] sampled in cycle c: `stage_en_o[k+1]`=1 in c+1. For the last stage, `done_o`=1 in c+1.
- Enable set in cycle e with no ack: `error_o`=1 in e+2^`lg_timeout_p`. Ack sampled at e+2^`lg_timeout_p`-1 or earlier succeeds.
- Best-case full bring-up, acks tied high: `done_o` rises `num_stages_p`+1 cycles after `ready_i`.
- Reset assertion clears all flops immediately, mid-sequence included. Reset release is synchronous to `clk_i` as supplied by the upstream reset logic.

## Configuration
- Macro: `BSG_STARTUP_SEQ_ACK_SYNC_EN`.
- Defined: each `stage_ack_i` bit passes through a two-flop synchronizer before use. Every ack-related latency grows by 2 cycles, and the timeout window counts from the enable, not from the synchronized ack.
- Undefined: acks are sampled directly and must be synchronous to `clk_i`.

## Structure
- Package `bsg_startup_seq_pkg` holds:
  - The state enum typedef.
  - The encoding constants for `WAIT_READY`, `STAGE`, `DONE` and `ERROR`.
- Sub-module `bsg_sync_sync` provides the two-flop ack synchronizer, instantiated only under the macro.
- Everything else lives in one module.

## Test plan
All scenarios use `num_stages_p`=4, `lg_timeout_p`=3 and the macro undefined.
- Reset held, then `ready_i`=1 at cycle 10 with acks tied 1 -> `stage_en_o` goes 0001, 0011, 0111, 1111 in cycles 11–14; `done_o`=1 at cycle 15.
- Ack[2] withheld -> `stage_en_o`=0111 for 8 cycles, then `error_o`=1, `error_stage_o`=2, `stage_en_o`=0000.
- Ack[1] arrives on exactly the 8th cycle after `stage_en_o[1]`, with the timer at 7 -> sequence proceeds and `error_o` stays 0.
- `ready_i` dropped while k=2 -> next cycle all outputs are 0; re-raising `ready_i` restarts from stage 0.
- `reset_n_i` pulsed low for half a cycle mid-sequence -> outputs are 0 immediately, without waiting for a clock edge.
- Ack[3] high from the start and ack[1] low -> ack[3] ignored; error at stage 1.
